// File: rtl/watchdog_array_pkg.sv
// watchdog_array_pkg: width helpers shared by the watchdog array and its bench
package watchdog_array_pkg;
  function automatic int unsigned wd_clog2(input int unsigned n);
    for (int unsigned r = 0; r < 32; r++)
      if ((32'd1 << r) >= n) return r;
    return 32;
  endfunction
  function automatic int unsigned wd_bkt_w(input int unsigned nb);
    return wd_clog2(nb);
  endfunction
  function automatic int unsigned wd_chan_w(input int unsigned n);
    return (wd_clog2(n) < 1) ? 1 : wd_clog2(n);
  endfunction
endpackage

// File: rtl/watchdog_channel.sv
// watchdog_channel: one programmable expiry timer with wrapping bucket index
module watchdog_channel #(
  parameter int TW = 32,
  parameter logic [TW-1:0] DEF = '1,
  parameter int NB = 8,
  parameter int BW = 3,
  parameter int CH = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          oneshot,
  input  logic          kick,
  input  logic          wr,
  input  logic [TW-1:0] cfg_limit,
  output logic          update,
  output logic [BW-1:0] bucket,
  output logic          expired
);
  logic [TW-1:0] cnt_q, cnt_d, lim_q, lim_d;
  logic [BW-1:0] bkt_q, bkt_d;
  logic          exp_q, exp_d, upd_q, upd_d;
  logic          clr, hold, term;
  always_comb begin
    clr   = wr || kick;
    hold  = !enable || exp_q || (lim_q == '0);
    term  = cnt_q == lim_q - TW'(1);
    upd_d = !clr && !hold && term;
    lim_d = wr ? cfg_limit : lim_q;
    cnt_d = clr ? '0 : hold ? cnt_q : term ? '0 : cnt_q + TW'(1);
    bkt_d = !upd_d ? bkt_q : (bkt_q == BW'(NB - 1)) ? '0 : bkt_q + BW'(1);
    exp_d = clr ? 1'b0 : (upd_d && oneshot) ? 1'b1 : exp_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      lim_q <= DEF;
      bkt_q <= '0;
      exp_q <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
      bkt_q <= bkt_d;
      exp_q <= exp_d;
      upd_q <= upd_d;
    end
  end
`ifndef SYNTHESIS
  always @(posedge clk) if (!reset && upd_d && !upd_q) $display("watchdog ch%0d update", CH);
`endif
  assign update  = upd_q;
  assign bucket  = bkt_q;
  assign expired = exp_q;
endmodule

// File: rtl/watchdog_array.sv
// watchdog_array: NUM_CHANNELS independent update timers sharing one limit-write bus
module watchdog_array
  import watchdog_array_pkg::*;
#(
  parameter int          NUM_CHANNELS  = 4,
  parameter int          TIMER_WIDTH   = 32,
  parameter logic [31:0] DEFAULT_LIMIT = 32'h3fff_ffff,
  parameter int          NUM_BUCKETS   = 8,
  localparam int         BKT_W         = wd_bkt_w(NUM_BUCKETS),
  localparam int         CHAN_W        = wd_chan_w(NUM_CHANNELS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_CHANNELS-1:0]         enable,
  input  logic [NUM_CHANNELS-1:0]         oneshot,
  input  logic [NUM_CHANNELS-1:0]         kick,
  input  logic                            cfg_wr,
  input  logic [CHAN_W-1:0]               cfg_chan,
  input  logic [TIMER_WIDTH-1:0]          cfg_limit,
  output logic [NUM_CHANNELS-1:0]         update,
  output logic [NUM_CHANNELS*BKT_W-1:0]   bucket_idx,
  output logic [NUM_CHANNELS-1:0]         expired
);
  genvar i;
  generate
    for (i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      watchdog_channel #(
        .TW (TIMER_WIDTH),
        .DEF(TIMER_WIDTH'(DEFAULT_LIMIT)),
        .NB (NUM_BUCKETS),
        .BW (BKT_W),
        .CH (i)
      ) u_ch (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable[i]),
        .oneshot  (oneshot[i]),
        .kick     (kick[i]),
        .wr       (cfg_wr && (cfg_chan == CHAN_W'(i))),
        .cfg_limit(cfg_limit),
        .update   (update[i]),
        .bucket   (bucket_idx[i*BKT_W +: BKT_W]),
        .expired  (expired[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_watchdog_array.sv
// tb_watchdog_array: directed checks of a 2-channel, limit-5, 3-bucket array plus a 1-channel copy
module tb_watchdog_array;
  logic       clk = 0, reset = 1;
  logic [1:0] enable = 0, oneshot = 0, kick = 0;
  logic       cfg_wr = 0;
  logic [0:0] cfg_chan = 0;
  logic [7:0] cfg_limit = 0;
  logic [1:0] update, expired;
  logic [3:0] bucket_idx;
  logic [0:0] en1 = 0, os1 = 0, kick1 = 0, upd1, exp1;
  logic       wr1 = 0;
  logic [0:0] chan1 = 0;
  logic [7:0] lim1 = 0;
  logic [1:0] bkt1;
  int total = 0, passed = 0;

  watchdog_array #(.NUM_CHANNELS(2), .TIMER_WIDTH(8), .DEFAULT_LIMIT(32'd5), .NUM_BUCKETS(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .oneshot(oneshot), .kick(kick),
    .cfg_wr(cfg_wr), .cfg_chan(cfg_chan), .cfg_limit(cfg_limit),
    .update(update), .bucket_idx(bucket_idx), .expired(expired));

  watchdog_array #(.NUM_CHANNELS(1), .TIMER_WIDTH(8), .DEFAULT_LIMIT(32'd5), .NUM_BUCKETS(3)) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .oneshot(os1), .kick(kick1),
    .cfg_wr(wr1), .cfg_chan(chan1), .cfg_limit(lim1),
    .update(upd1), .bucket_idx(bkt1), .expired(exp1));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1; enable = 0; oneshot = 0; kick = 0; cfg_wr = 0; cfg_chan = 0; cfg_limit = 0;
    en1 = 0; os1 = 0; kick1 = 0; wr1 = 0; chan1 = 0; lim1 = 0;
    tick;
    reset = 0;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({update, bucket_idx, expired, upd1, bkt1, exp1} !== 12'd0)
      $display("FAIL reset outputs=%h want 000", {update, bucket_idx, expired, upd1, bkt1, exp1});
    else passed++;
    reset = 0;
  endtask

  task automatic test_periodic;
    do_reset;
    enable = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      logic [1:0] b;
      logic       u;
      tick;
      u = (k % 5) == 0;
      b = 2'((k / 5) % 3);
      total++;
      if (update !== {u, u} || bucket_idx !== {b, b} || expired !== 2'b00)
        $display("FAIL periodic k=%0d upd=%b bkt=%h exp=%b want upd=%b bkt=%h exp=00", k, update, bucket_idx, expired, {u, u}, {b, b});
      else passed++;
    end
  endtask

  task automatic test_cfg_write;
    do_reset;
    enable = 2'b11;
    repeat (5) tick;
    cfg_wr = 1; cfg_chan = 1; cfg_limit = 8'd2;
    tick;
    cfg_wr = 0;
    total++;
    if (update !== 2'b00 || bucket_idx[3:2] !== 2'd1)
      $display("FAIL cfg_write_edge upd=%b bkt1=%0d want upd=00 bkt1=1", update, bucket_idx[3:2]);
    else passed++;
    for (int k = 1; k <= 10; k++) begin
      logic [1:0] e, b;
      tick;
      e = {(k % 2) == 0, ((6 + k) % 5) == 0};
      b = 2'((1 + k / 2) % 3);
      total++;
      if (update !== e || bucket_idx[3:2] !== b)
        $display("FAIL cfg_write k=%0d upd=%b bkt1=%0d want upd=%b bkt1=%0d", k, update, bucket_idx[3:2], e, b);
      else passed++;
    end
  endtask

  task automatic test_kick;
    do_reset;
    enable = 2'b01;
    repeat (3) tick;
    kick = 2'b01;
    tick;
    kick = 0;
    total++;
    if (update[0] !== 1'b0) $display("FAIL kick_mid upd=%b want 0", update[0]);
    else passed++;
    for (int k = 1; k <= 5; k++) begin
      tick;
      total++;
      if (update[0] !== (k == 5)) $display("FAIL kick_after k=%0d upd=%b want %b", k, update[0], k == 5);
      else passed++;
    end
    repeat (4) tick;
    kick = 2'b01;
    tick;
    kick = 0;
    total++;
    if (update[0] !== 1'b0 || bucket_idx[1:0] !== 2'd1)
      $display("FAIL kick_terminal upd=%b bkt=%0d want upd=0 bkt=1", update[0], bucket_idx[1:0]);
    else passed++;
    for (int k = 1; k <= 5; k++) begin
      tick;
      total++;
      if (update[0] !== (k == 5)) $display("FAIL kick_term_after k=%0d upd=%b want %b", k, update[0], k == 5);
      else passed++;
    end
  endtask

  task automatic test_oneshot;
    do_reset;
    enable = 2'b01; oneshot = 2'b01;
    repeat (5) tick;
    total++;
    if (update[0] !== 1'b1 || expired[0] !== 1'b1)
      $display("FAIL oneshot_fire upd=%b exp=%b want 1 1", update[0], expired[0]);
    else passed++;
    for (int k = 1; k <= 20; k++) begin
      tick;
      total++;
      if ({update[0], expired[0]} !== 2'b01)
        $display("FAIL oneshot_silent k=%0d upd=%b exp=%b want 0 1", k, update[0], expired[0]);
      else passed++;
    end
    oneshot = 0;
    tick;
    total++;
    if (expired[0] !== 1'b1) $display("FAIL oneshot_clear_mode exp=%b want 1", expired[0]);
    else passed++;
    oneshot = 2'b01; kick = 2'b01;
    tick;
    kick = 0;
    total++;
    if (expired[0] !== 1'b0) $display("FAIL oneshot_kick exp=%b want 0", expired[0]);
    else passed++;
    for (int k = 1; k <= 5; k++) begin
      tick;
      total++;
      if (update[0] !== (k == 5)) $display("FAIL oneshot_rearm k=%0d upd=%b want %b", k, update[0], k == 5);
      else passed++;
    end
  endtask

  task automatic test_limits;
    do_reset;
    enable = 2'b11; en1 = 1;
    cfg_wr = 1; cfg_chan = 0; cfg_limit = 8'd0;
    wr1 = 1; chan1 = 1; lim1 = 8'd2;
    tick;
    wr1 = 0;
    cfg_chan = 1; cfg_limit = 8'd1;
    tick;
    cfg_wr = 0;
    for (int k = 1; k <= 10; k++) begin
      logic [1:0] b;
      logic       u1;
      tick;
      b = 2'(k % 3);
      u1 = ((k + 2) % 5) == 0;
      total++;
      if (update !== 2'b10 || bucket_idx !== {b, 2'd0})
        $display("FAIL limits k=%0d upd=%b bkt=%h want upd=10 bkt=%h", k, update, bucket_idx, {b, 2'd0});
      else passed++;
      total++;
      if (upd1 !== u1) $display("FAIL out_of_range k=%0d upd=%b want %b", k, upd1, u1);
      else passed++;
    end
  endtask

  task automatic test_enable_gap;
    do_reset;
    enable = 2'b01;
    repeat (2) tick;
    enable = 0;
    for (int k = 1; k <= 7; k++) begin
      tick;
      total++;
      if (update[0] !== 1'b0) $display("FAIL gap_hold k=%0d upd=%b want 0", k, update[0]);
      else passed++;
    end
    enable = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      tick;
      total++;
      if (update[0] !== (k == 3)) $display("FAIL gap_resume k=%0d upd=%b want %b", k, update[0], k == 3);
      else passed++;
    end
  endtask

  task automatic test_async_reset;
    do_reset;
    enable = 2'b01;
    cfg_wr = 1; cfg_chan = 0; cfg_limit = 8'd3;
    tick;
    cfg_wr = 0;
    repeat (3) tick;
    total++;
    if (update[0] !== 1'b1 || bucket_idx[1:0] !== 2'd1)
      $display("FAIL async_pre upd=%b bkt=%0d want 1 1", update[0], bucket_idx[1:0]);
    else passed++;
    #3 reset = 1;
    #1;
    total++;
    if (update !== 2'b00 || bucket_idx !== 4'd0 || expired !== 2'b00)
      $display("FAIL async_reset upd=%b bkt=%h exp=%b want 0 0 0", update, bucket_idx, expired);
    else passed++;
    #1 reset = 0;
    for (int k = 1; k <= 5; k++) begin
      tick;
      total++;
      if (update[0] !== (k == 5)) $display("FAIL async_default_limit k=%0d upd=%b want %b", k, update[0], k == 5);
      else passed++;
    end
  endtask

  initial begin
    test_reset;
    test_periodic;
    test_cfg_write;
    test_kick;
    test_oneshot;
    test_limits;
    test_enable_gap;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/watchdog_array.md
Name: watchdog_array

Overview:
- Multi-channel, runtime-programmable successor to the single fixed-limit update timer.
- Each channel raises a 1-cycle update pulse every LIMIT enabled clock cycles and advances a wrapping bucket index.
- Bloom-filter bucket rotation and aging logic consume update and bucket_idx directly.
- Adds per-channel limit registers, a one-shot mode, a kick (restart) input and an exact period; the old block's period was LIMIT+1.

Parameters:
- NUM_CHANNELS, 4, number of independent timer channels.
- TIMER_WIDTH, 32, width of each counter and limit register.
- DEFAULT_LIMIT, 32'h3fff_ffff, limit loaded into every channel at reset; truncated to TIMER_WIDTH.
- NUM_BUCKETS, 8, modulus of each channel's bucket index; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  NUM_CHANNELS  per-channel count enable.
- oneshot  in  NUM_CHANNELS  per-channel mode: 1 = one-shot, 0 = periodic; sampled every cycle.
- kick  in  NUM_CHANNELS  per-channel synchronous restart pulse.
- cfg_wr  in  1  limit write strobe.
- cfg_chan  in  log2(NUM_CHANNELS), min 1  target channel of the write.
- cfg_limit  in  TIMER_WIDTH  new limit value.
- update  out  NUM_CHANNELS  registered 1-cycle expiry pulse per channel.
- bucket_idx  out  NUM_CHANNELS*log2(NUM_BUCKETS)  current bucket per channel; channel i occupies slice i.
- expired  out  NUM_CHANNELS  sticky one-shot done flag per channel.

Behaviour:
- Reset values (asynchronous, applied immediately):
  - counter = 0, limit = DEFAULT_LIMIT
  - update = 0, bucket_idx = 0, expired = 0
- Per-channel priority at each posedge, highest first:
  1. cfg_wr && cfg_chan == i: limit <= cfg_limit, counter <= 0, expired <= 0, update <= 0; bucket_idx unchanged.
  2. kick[i]: counter <= 0, expired <= 0, update <= 0; bucket_idx unchanged.
  3. Hold condition (!enable[i], or expired[i], or limit == 0): counter holds, update <= 0.
  4. Terminal count (counter == limit-1):
     - counter <= 0, update <= 1
     - bucket_idx <= (bucket_idx == NUM_BUCKETS-1) ? 0 : bucket_idx + 1
     - if oneshot[i], expired <= 1
  5. Otherwise: counter <= counter + 1, update <= 0.
- Period:
  - Exactly `limit` enabled cycles between update pulses.
  - With enable held high from a counter of 0, update is high in the cycle after the edge at which counter == limit-1.
- Limit values:
  - limit == 1: update stays high on every enabled cycle and bucket_idx advances every cycle.
  - limit == 0: channel is dormant; it never fires.
- cfg_chan >= NUM_CHANNELS: write is ignored; no channel changes.
- Write to channel i at the same edge as its terminal count: the write wins; no update pulse and no bucket advance.
- Kick at the same edge as the terminal count: the kick wins; no pulse.
- One-shot channel after firing: it counts no further until a kick or limit write. Clearing oneshot does not clear expired.
- Periodic mode: expired is never set.
- enable dropping mid-count: the counter freezes and resumes from the same value on re-enable.
- Counter arithmetic is unsigned TIMER_WIDTH. The counter can never exceed limit-1, because a write always zeroes it.
- Channels are fully independent; no cross-channel interaction except the shared cfg bus.
- Simulation only: a $display on each update rising edge, reporting the channel number, is excluded from synthesis.

Decomposition:
- Shared package/include:
  - log2 (ceil) function
  - bucket-index width localparam
  - cfg_chan width localparam (min 1)
- One sub-module, watchdog_channel:
  - holds counter, limit, bucket, expired and update for one channel
  - takes the decoded write strobe
  - instantiated NUM_CHANNELS times via generate
- Top level contains only the cfg_chan decode and port slicing.

Test Plan:
Bench parameters: NUM_CHANNELS=2, TIMER_WIDTH=8, DEFAULT_LIMIT=5, NUM_BUCKETS=3.
- Reset, then enable=2'b11, oneshot=0 -> update[0] pulses every 5 cycles, first pulse 5 cycles after enable. bucket_idx[0] follows 1,2,0,1.
- Write cfg_chan=1, limit=2 -> update[1] pulses every 2 cycles. Channel 0 keeps its 5-cycle period. bucket_idx[1] is unchanged by the write.
- Kick ch0 at counter=3 -> no pulse; the next update[0] comes 5 cycles after the kick. Kick at counter=4 (terminal) -> no pulse at that edge.
- oneshot[0]=1 -> a single update[0] pulse, then expired[0]=1 and silence for 20 cycles. Kick -> expired=0 and the next pulse comes 5 cycles later.
- Limits 0 and 1, and cfg_chan=1 with NUM_CHANNELS=1 variant (out of range):
  - limit=0 -> never fires.
  - limit=1 -> update held high while enabled.
  - out-of-range write -> ignored.
- enable low for 7 cycles mid-count, then high -> the pulse is delayed by exactly 7 cycles.
- Assert reset mid-count without a clock edge -> outputs go to 0 immediately and limit returns to 5.
